// File: rtl/datapath_pkg.sv
// Shared datapath types: the 32-bit word and the fetch bundle handed to the scoreboard.
package datapath_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  valid;
        word_t pc;
        word_t instr;
    } fetch_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fq_entry_t;

    function automatic word_t word_align(input word_t a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with wrap-around pointers; clear wins over push and pop.
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [63:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop;

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: single-outstanding instruction reads into a small queue feeding the scoreboard,
// with flush/redirect that drains any in-flight request before fetching the new path.
module fetch_stage
    import datapath_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    FQ_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    output logic                      imem_ren,
    output word_t                     imem_addr,
    input  logic                      imem_ready,
    input  word_t                     imem_rdata,
    input  logic                      freeze,
    input  logic                      flush,
    input  word_t                     redirect_pc,
    output fetch_t                    fetch,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        addr_q, addr_d;
    logic         ren_q, ren_d;

    fq_entry_t    head;
    fq_entry_t    push_entry;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic         fq_valid;
    logic         push;
    logic         pop;
    logic         room;

    assign fq_valid    = (count != '0);
    assign pop         = fq_valid && !freeze;
    assign push        = (state_q == FETCH) && imem_ready && !flush;
    assign count_after = count + CW'(push) - CW'(pop);
    assign room        = count_after < CW'(FQ_DEPTH);
    assign push_entry  = '{pc: pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (fq_entry_t)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    pc_d    = word_align(redirect_pc);
                    state_d = FETCH;
                end else if (room) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (flush) begin
                    pc_d    = word_align(redirect_pc);
                    state_d = imem_ready ? FETCH : DRAIN;
                end else if (imem_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = room ? FETCH : IDLE;
                end
            end
            DRAIN: begin
                if (flush)      pc_d    = word_align(redirect_pc);
                if (imem_ready) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // Memory outputs are registered from the next state; DRAIN keeps the abandoned address.
        ren_d = (state_d != IDLE);
        case (state_d)
            FETCH:   addr_d = pc_d;
            DRAIN:   addr_d = addr_q;
            default: addr_d = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            pc_q    <= word_align(RESET_PC);
            ren_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ren_q   <= ren_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        fetch       = '0;
        fetch.valid = fq_valid;
        if (fq_valid) begin
            fetch.pc    = head.pc;
            fetch.instr = head.instr;
        end
    end

    assign imem_ren  = ren_q;
    assign imem_addr = addr_q;
    assign fq_count  = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected pcs, a negedge monitor checks pops.
module tb_fetch_stage;
    import datapath_pkg::*;

    localparam word_t MAGIC = 32'hC0DE_0000;

    logic   CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic   nRST;
    logic   imem_ren, imem_ready;
    word_t  imem_addr, imem_rdata;
    logic   freeze, flush;
    word_t  redirect_pc;
    fetch_t fetch;
    logic [2:0] fq_count;

    logic   imem_ren2, imem_ready2;
    word_t  imem_addr2, imem_rdata2;
    logic   freeze2, flush2;
    word_t  redirect_pc2;
    fetch_t fetch2;
    logic [2:0] fq_count2;

    int     tests = 0;
    int     fails = 0;
    word_t  sb[$];
    word_t  mon_exp;
    int     lat = 0;
    int     wait_cnt;

    fetch_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .imem_ren(imem_ren), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .freeze(freeze), .flush(flush), .redirect_pc(redirect_pc),
        .fetch(fetch), .fq_count(fq_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(4)) dut_wrap (
        .CLK(CLK), .nRST(nRST),
        .imem_ren(imem_ren2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
        .freeze(freeze2), .flush(flush2), .redirect_pc(redirect_pc2),
        .fetch(fetch2), .fq_count(fq_count2)
    );

    // Memory model: response after `lat` waiting cycles (0 = same cycle); instr = addr ^ MAGIC.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)                          wait_cnt <= 0;
        else if (!imem_ren || imem_ready)   wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end
    assign imem_ready   = imem_ren && (wait_cnt >= lat);
    assign imem_rdata   = imem_addr ^ MAGIC;
    assign imem_ready2  = imem_ren2;
    assign imem_rdata2  = imem_addr2 ^ MAGIC;
    assign freeze2      = 1'b0;
    assign flush2       = 1'b0;
    assign redirect_pc2 = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST && fetch.valid && !freeze && !flush) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_fetch: got pc %h, expected none", fetch.pc);
            end else begin
                mon_exp = sb.pop_front();
                chk("fetch_pc", fetch.pc, mon_exp);
                chk("fetch_instr", fetch.instr, mon_exp ^ MAGIC);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        flush = 1'b0;
        redirect_pc = '0;
        sb.delete();
        step(2);
        chk("rst_ren", 32'(imem_ren), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_fetch", {31'd0, fetch.valid} | fetch.pc | fetch.instr, 32'd0);
        chk("rst_count", 32'(fq_count), 32'd0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        chk({name, "_drained"}, 32'(sb.size()), 32'd0);
        freeze = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        redirect_pc = '0;

        // Streaming with single-cycle memory, plus wrap-around instance.
        do_reset();
        lat = 0;
        freeze = 1'b0;
        for (int i = 0; i < 10; i++) sb.push_back(32'(4 * i));
        nRST = 1'b1;
        step(1);
        chk("s1_ren", 32'(imem_ren), 32'd1);
        chk("s1_addr", imem_addr, 32'h0);
        chk("s1_valid", 32'(fetch.valid), 32'd0);
        chk("w1_addr", imem_addr2, 32'hFFFF_FFF8);
        step(1);
        chk("s2_valid", 32'(fetch.valid), 32'd1);
        chk("s2_addr", imem_addr, 32'h4);
        chk("w2_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("w2_pc", fetch2.pc, 32'hFFFF_FFF8);
        step(1);
        chk("s3_addr", imem_addr, 32'h8);
        chk("w3_addr", imem_addr2, 32'h0);
        chk("w3_pc", fetch2.pc, 32'hFFFF_FFFC);
        step(1);
        chk("w4_pc", fetch2.pc, 32'h0);
        drain("stream");

        // Freeze: queue fills to 4 and requests stop, then releases in order.
        do_reset();
        lat = 0;
        freeze = 1'b1;
        nRST = 1'b1;
        step(11);
        chk("frz_count", 32'(fq_count), 32'd4);
        chk("frz_ren", 32'(imem_ren), 32'd0);
        chk("frz_head", fetch.pc, 32'h0);
        for (int i = 0; i < 5; i++) sb.push_back(32'(4 * i));
        freeze = 1'b0;
        drain("freeze");

        // Flush while a 3-cycle request is pending: drain old address, then 0x100.
        do_reset();
        lat = 3;
        freeze = 1'b0;
        sb.push_back(32'h0);
        nRST = 1'b1;
        step(6);
        chk("dr_pre_addr", imem_addr, 32'h4);
        sb.push_back(32'h100);
        sb.push_back(32'h104);
        flush = 1'b1;
        redirect_pc = 32'h100;
        step(1);
        flush = 1'b0;
        chk("dr_ren", 32'(imem_ren), 32'd1);
        chk("dr_addr_hold", imem_addr, 32'h4);
        chk("dr_valid", 32'(fetch.valid), 32'd0);
        step(1);
        chk("dr_addr_hold2", imem_addr, 32'h4);
        step(1);
        chk("dr_new_addr", imem_addr, 32'h100);
        chk("dr_count", 32'(fq_count), 32'd0);
        drain("drain");

        // Flush coinciding with imem_ready and a pop.
        do_reset();
        lat = 0;
        freeze = 1'b0;
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        nRST = 1'b1;
        step(4);
        chk("fr_head", fetch.pc, 32'h8);
        chk("fr_ready", 32'(imem_ready), 32'd1);
        sb.push_back(32'h200);
        sb.push_back(32'h204);
        sb.push_back(32'h208);
        flush = 1'b1;
        redirect_pc = 32'h200;
        step(1);
        flush = 1'b0;
        chk("fr_valid", 32'(fetch.valid), 32'd0);
        chk("fr_count", 32'(fq_count), 32'd0);
        chk("fr_addr", imem_addr, 32'h200);
        drain("flush_ready");

        // Reset mid-request with a loaded queue, then restart at RESET_PC.
        do_reset();
        lat = 0;
        freeze = 1'b1;
        nRST = 1'b1;
        step(4);
        chk("mr_count", 32'(fq_count), 32'd3);
        chk("mr_ren", 32'(imem_ren), 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("mr_rst_ren", 32'(imem_ren), 32'd0);
        chk("mr_rst_addr", imem_addr, 32'd0);
        chk("mr_rst_valid", 32'(fetch.valid), 32'd0);
        chk("mr_rst_count", 32'(fq_count), 32'd0);
        step(1);
        freeze = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(32'(4 * i));
        nRST = 1'b1;
        step(1);
        chk("mr_restart_addr", imem_addr, 32'h0);
        chk("mr_restart_ren", 32'(imem_ren), 32'd1);
        drain("reset_restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
